// File: rtl/aes_scan_test_ctrl_if.sv
// Scan/handshake bundle between the test sequencer (master) and the external AES core (slave).
interface aes_scan_test_ctrl_if;
  logic SO, BSY;
  logic Krdy1, Drdy1, RSTn1, EN1, SU1, SI1, SE1, SCLK;

  modport master (input SO, BSY,
                  output Krdy1, Drdy1, RSTn1, EN1, SU1, SI1, SE1, SCLK);
  modport slave  (output SO, BSY,
                  input Krdy1, Drdy1, RSTn1, EN1, SU1, SI1, SE1, SCLK);
endinterface

// File: rtl/aes_scan_test_ctrl.sv
// Scan-based AES core test sequencer: load key/pt, wait, unload ct, compare, drive LEDs.
// Define BSY_TIMEOUT_EN to abort to a fail result when BSY waits exceed BSY_TIMEOUT cycles.
module aes_scan_test_ctrl #(
  parameter int SCLK_HALF   = 1,
  parameter int RST_CYCLES  = 8,
  parameter int BSY_TIMEOUT = 1024
) (
  input  logic                        CLK,
  input  logic                        reset1,
  input  logic                        start1,
  input  logic                        input2,
  aes_scan_test_ctrl_if.master        core,
  output logic                        led1,
  output logic                        led2
);
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;

  localparam int HW    = $clog2(SCLK_HALF + 1);
  localparam int CNT_W = $clog2(BSY_TIMEOUT + RST_CYCLES + 17);
  localparam logic [HW-1:0]    HALF_M1 = HW'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] RST_M1  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENC_M1  = CNT_W'(15);
`ifdef BSY_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(BSY_TIMEOUT - 1);
`endif

  typedef enum logic [3:0] {
    IDLE, RST_CORE, LOAD_KEY, KEY_UPD, WAIT_KEY, LOAD_DATA,
    DATA_UPD, WAIT_ENC, CAPTURE, UNLOAD, CHECK, DONE
  } state_t;

  state_t           state;
  logic             armed, sel, seen_bsy;
  logic [CNT_W-1:0] cnt;
  logic [HW-1:0]    hcnt;
  logic [6:0]       bit_cnt;
  logic [127:0]     sh, res;
  logic [127:0]     key_v, pt_v, ct_v;
  logic             half_end, bit_end, last_bit;

  assign key_v    = sel ? KEY1 : KEY0;
  assign pt_v     = sel ? PT1  : PT0;
  assign ct_v     = sel ? CT1  : CT0;
  assign half_end = (hcnt == HALF_M1);
  assign bit_end  = half_end && core.SCLK;
  assign last_bit = (bit_cnt == 7'd127);

  always_ff @(posedge CLK) begin
    if (reset1) begin
      state      <= IDLE;
      armed      <= 1'b1;
      sel        <= 1'b0;
      seen_bsy   <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      res        <= '0;
      core.RSTn1 <= 1'b1;
      core.Krdy1 <= 1'b0;
      core.Drdy1 <= 1'b0;
      core.EN1   <= 1'b0;
      core.SU1   <= 1'b0;
      core.SI1   <= 1'b0;
      core.SE1   <= 1'b0;
      core.SCLK  <= 1'b0;
      led1       <= 1'b0;
      led2       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start1 && armed) begin
          sel        <= input2;
          led1       <= 1'b0;
          led2       <= 1'b0;
          cnt        <= '0;
          core.RSTn1 <= 1'b0;
          core.EN1   <= 1'b1;
          state      <= RST_CORE;
        end
        RST_CORE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == RST_M1) begin
            core.RSTn1 <= 1'b1;
            core.SE1   <= 1'b1;
            core.SI1   <= key_v[127];
            sh         <= key_v;
            hcnt       <= '0;
            bit_cnt    <= '0;
            state      <= LOAD_KEY;
          end
        end
        // Shared bit engine: SCLK low then high for SCLK_HALF cycles each; SI
        // advances on the falling transition so it is stable across the rise.
        LOAD_KEY, LOAD_DATA, CAPTURE, UNLOAD: begin
          hcnt <= half_end ? '0 : hcnt + HW'(1);
          if (half_end) core.SCLK <= ~core.SCLK;
          if (half_end && !core.SCLK && state == UNLOAD) res <= {res[126:0], core.SO};
          if (bit_end) begin
            sh       <= {sh[126:0], 1'b0};
            core.SI1 <= sh[126];
            bit_cnt  <= bit_cnt + 7'd1;
          end
          if (bit_end && (last_bit || state == CAPTURE)) begin
            bit_cnt  <= '0;
            core.SE1 <= 1'b0;
            core.SI1 <= 1'b0;
            case (state)
              LOAD_KEY: begin
                core.SU1   <= 1'b1;
                core.Krdy1 <= 1'b1;
                state      <= KEY_UPD;
              end
              LOAD_DATA: begin
                core.SU1   <= 1'b1;
                core.Drdy1 <= 1'b1;
                state      <= DATA_UPD;
              end
              CAPTURE: begin
                core.SE1 <= 1'b1;
                sh       <= '0;
                state    <= UNLOAD;
              end
              default: state <= CHECK;
            endcase
          end
        end
        KEY_UPD, DATA_UPD: begin
          core.SU1   <= 1'b0;
          core.Krdy1 <= 1'b0;
          core.Drdy1 <= 1'b0;
          cnt        <= '0;
          seen_bsy   <= 1'b0;
          state      <= (state == KEY_UPD) ? WAIT_KEY : WAIT_ENC;
        end
        WAIT_KEY: begin
          cnt <= cnt + CNT_W'(1);
          if (!core.BSY) begin
            core.SE1 <= 1'b1;
            core.SI1 <= pt_v[127];
            sh       <= pt_v;
            hcnt     <= '0;
            bit_cnt  <= '0;
            state    <= LOAD_DATA;
          end
`ifdef BSY_TIMEOUT_EN
          else if (cnt == TO_M1) begin
            led1     <= 1'b0;
            led2     <= 1'b1;
            core.EN1 <= 1'b0;
            armed    <= 1'b0;
            state    <= DONE;
          end
`endif
        end
        // A core that finishes before BSY is ever observed is accepted after 16 idle cycles.
        WAIT_ENC: begin
          cnt <= cnt + CNT_W'(1);
          if (core.BSY) seen_bsy <= 1'b1;
          if (!core.BSY && (seen_bsy || cnt >= ENC_M1)) begin
            hcnt  <= '0;
            state <= CAPTURE;
          end
`ifdef BSY_TIMEOUT_EN
          else if (cnt == TO_M1) begin
            led1     <= 1'b0;
            led2     <= 1'b1;
            core.EN1 <= 1'b0;
            armed    <= 1'b0;
            state    <= DONE;
          end
`endif
        end
        CHECK: begin
          led1     <= (res == ct_v);
          led2     <= (res != ct_v);
          core.EN1 <= 1'b0;
          armed    <= 1'b0;
          state    <= DONE;
        end
        DONE: if (!start1) begin
          armed <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_scan_test_ctrl.sv
// Directed bench: behavioural scan-chain AES core model answering with a chosen ciphertext.
module tb_aes_scan_test_ctrl;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [9:0]   RST_OUTS = 10'b0010000000;

  logic CLK = 1'b0;
  logic reset1, start1, input2, led1, led2;
  aes_scan_test_ctrl_if dif();

  aes_scan_test_ctrl dut (
    .CLK(CLK), .reset1(reset1), .start1(start1), .input2(input2),
    .core(dif), .led1(led1), .led2(led2)
  );

  always #5 CLK = ~CLK;

  // core model
  logic [127:0] sin = '0, sout = '0, resp = '0;
  logic [127:0] key_cap = '0, pt_cap = '0;
  int bsy_len = 0, bsy_cnt = 0, krdy_n = 0;
  logic both_led = 1'b0, ovl = 1'b0;

  assign dif.SO  = sout[127];
  assign dif.BSY = (bsy_cnt != 0);

  always @(posedge dif.SCLK) begin
    if (dif.SE1) begin
      sin  <= {sin[126:0], dif.SI1};
      sout <= {sout[126:0], 1'b0};
    end else sout <= resp;
  end

  always @(posedge CLK) begin
    if (dif.Krdy1 || dif.Drdy1) bsy_cnt <= bsy_len;
    else if (bsy_cnt > 0)       bsy_cnt <= bsy_cnt - 1;
    if (dif.Krdy1) begin key_cap <= sin; krdy_n <= krdy_n + 1; end
    if (dif.Drdy1) pt_cap <= sin;
    if (led1 && led2) both_led <= 1'b1;
    if ((dif.Krdy1 || dif.Drdy1 || dif.SU1) && dif.SCLK) ovl <= 1'b1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {dif.Krdy1, dif.Drdy1, dif.RSTn1, dif.EN1, dif.SU1,
            dif.SI1, dif.SE1, dif.SCLK, led1, led2};
  endfunction

  task automatic do_run(input logic s, input logic [127:0] r, input int blen, output int cyc);
    input2 = s; resp = r; bsy_len = blen;
    @(negedge CLK); start1 = 1'b1;
    cyc = 0;
    @(negedge CLK);
    while (!(led1 || led2) && cyc < 2500) begin
      @(negedge CLK); cyc++;
    end
    chk("latency", 128'(cyc < 2500), 128'd1);
  endtask

  initial begin
    int cyc, n, w;
    reset1 = 1'b1; start1 = 1'b0; input2 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_outs", 128'(outs()), 128'(RST_OUTS));
    reset1 = 1'b0;
    repeat (2) @(negedge CLK);
    chk("idle_outs", 128'(outs()), 128'(RST_OUTS));

    // vector 0, correct ct, BSY pulses
    do_run(1'b0, CT0, 5, cyc);
    chk("v0_led1", 128'(led1), 128'd1);
    chk("v0_led2", 128'(led2), 128'd0);
    chk("v0_key", key_cap, KEY0);
    chk("v0_pt", pt_cap, PT0);
    n = krdy_n;
    repeat (40) @(negedge CLK);
    chk("no_rerun", 128'(krdy_n), 128'(n));
    chk("en_done", 128'(dif.EN1), 128'd0);
    chk("led_hold", 128'(led1), 128'd1);
    start1 = 1'b0;
    repeat (3) @(negedge CLK);

    // vector 1, BSY never asserted (16-cycle fallback)
    do_run(1'b1, CT1, 0, cyc);
    chk("v1_led1", 128'(led1), 128'd1);
    chk("v1_led2", 128'(led2), 128'd0);
    chk("v1_key", key_cap, KEY1);
    chk("v1_pt", pt_cap, PT1);
    chk("rerun_cnt", 128'(krdy_n), 128'(n + 1));
    start1 = 1'b0;
    repeat (3) @(negedge CLK);

    // wrong ciphertext (LSB flipped)
    do_run(1'b0, CT0 ^ 128'd1, 3, cyc);
    chk("bad_led1", 128'(led1), 128'd0);
    chk("bad_led2", 128'(led2), 128'd1);
    start1 = 1'b0;
    repeat (3) @(negedge CLK);

    // reset mid LOAD_DATA, start1 kept high
    input2 = 1'b1; resp = CT1; bsy_len = 2;
    start1 = 1'b1;
    w = 0;
    while (!dif.Krdy1 && w < 1000) begin @(negedge CLK); w++; end
    chk("krdy_seen", 128'(w < 1000), 128'd1);
    repeat (60) @(negedge CLK);
    chk("in_load", 128'(dif.SE1), 128'd1);
    reset1 = 1'b1;
    @(negedge CLK);
    chk("abort_outs", 128'(outs()), 128'(RST_OUTS));
    reset1 = 1'b0;
    do_run(1'b1, CT1, 2, cyc);
    chk("restart_led1", 128'(led1), 128'd1);
    chk("restart_pt", pt_cap, PT1);
    start1 = 1'b0;
    repeat (3) @(negedge CLK);

    chk("led_excl", 128'(both_led), 128'd0);
    chk("pulse_sclk", 128'(ovl), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
